// File: rtl/acc_core_pkg.sv
// rtl/acc_core_pkg.sv - opcodes, FSM states and default widths for acc_core
package acc_core_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMM_W_DEF  = 4;
  localparam int PC_W_DEF   = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_NOR  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_LDR  = 4'h7,
    OP_STR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JMPR = 4'hA,
    OP_BRZ  = 4'hB,
    OP_BRN  = 4'hC,
    OP_BRC  = 4'hD,
    OP_RSV  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_regfile.sv
// rtl/acc_regfile.sv - 2^ADDR_W x DATA_W register file, async read, sync write
module acc_regfile
  import acc_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = IMM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/acc_core.sv
// rtl/acc_core.sv - accumulator core: fetch/exec/halt FSM, ALU, flags, PC
// Opcode D branches on carry only when ACC_CORE_BRC_EN is defined.
module acc_core
  import acc_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [IMM_W+3:0]  imem_data,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              halt
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IMM_W+3:0]  ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d;

  opcode_e           op;
  logic [IMM_W-1:0]  imm;
  logic [PC_W-1:0]   imm_pc;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic              upd_zn;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  assign op     = opcode_e'(ir_q[IMM_W+3:IMM_W]);
  assign imm    = ir_q[IMM_W-1:0];
  assign imm_pc = PC_W'(imm);

  acc_regfile #(.DATA_W(DATA_W), .ADDR_W(IMM_W)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (imm),
    .wdata (acc_q),
    .raddr (imm),
    .rdata (rf_rdata)
  );

  // SUB carry is the adder carry of ACC + ~R + 1, so 1 means no borrow
  always_comb begin
    sum     = '0;
    alu_res = acc_q;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, acc_q} + {1'b0, rf_rdata};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_SUB: begin
        sum     = {1'b0, acc_q} + {1'b0, ~rf_rdata} + (DATA_W+1)'(1);
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_NOR: alu_res = ~(acc_q | rf_rdata);
      OP_SHL: begin
        alu_res = {acc_q[DATA_W-2:0], 1'b0};
        alu_c   = acc_q[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, acc_q[DATA_W-1:1]};
        alu_c   = acc_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    rf_we   = 1'b0;
    upd_zn  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        // pc_q already points past this instruction; branches overwrite it
        case (op)
          OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
            acc_d  = alu_res;
            c_d    = alu_c;
            upd_zn = 1'b1;
          end
          OP_LDI: begin
            acc_d  = DATA_W'(imm);
            upd_zn = 1'b1;
          end
          OP_LDR: begin
            acc_d  = rf_rdata;
            upd_zn = 1'b1;
          end
          OP_STR:  rf_we = 1'b1;
          OP_JMP:  pc_d = imm_pc;
          OP_JMPR: pc_d = PC_W'(rf_rdata);
          OP_BRZ:  if (z_q) pc_d = imm_pc;
          OP_BRN:  if (n_q) pc_d = imm_pc;
`ifdef ACC_CORE_BRC_EN
          OP_BRC:  if (c_q) pc_d = imm_pc;
`endif
          OP_HLT:  state_d = ST_HALT;
          default: ;
        endcase
        if (upd_zn) begin
          z_d = (acc_d == '0);
          n_d = acc_d[DATA_W-1];
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH) && !reset;
  assign halt      = (state_q == ST_HALT) && !reset;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;

endmodule

// File: tb/tb_acc_core.sv
// tb/tb_acc_core.sv - scoreboard bench for acc_core against an ISA-level model
module tb_acc_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [3:0] pc;
  logic [7:0] acc;
  logic       flag_z, flag_n, flag_c, halt;

  acc_core dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .pc        (pc),
    .acc       (acc),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_halt;
    logic [3:0] pc;
    logic [7:0] acc;
    bit         z, n, c;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] prog [16];
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 0;

  int         wait_cnt = 0, cur_wait = 0, fix_wait = 0;
  bit         rand_wait = 0, spur_en = 0, hold_ack = 0, force_ack = 0;
  logic [7:0] force_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  // ISA-level reference: runs the program and queues the architectural state
  // seen at every fetch, plus the final state once HLT retires.
  task automatic model_run(input int max_steps);
    logic [3:0] mpc;
    logic [7:0] macc, rv;
    logic [7:0] mr [16];
    bit         mz, mn, mc, zn;
    int         op, imm, s;
    rec_t       rr;
    mpc = 0; macc = 0; mz = 0; mn = 0; mc = 0;
    for (int i = 0; i < 16; i++) mr[i] = 0;
    for (int st = 0; st < max_steps; st++) begin
      rr.is_halt = 0; rr.pc = mpc; rr.acc = macc; rr.z = mz; rr.n = mn; rr.c = mc;
      exp_q.push_back(rr);
      op  = int'(prog[mpc]) / 16;
      imm = int'(prog[mpc]) % 16;
      rv  = mr[imm];
      mpc = mpc + 4'd1;
      zn  = 0;
      case (op)
        1: begin s = int'(macc) + int'(rv); mc = (s > 255); macc = 8'(s); zn = 1; end
        2: begin mc = (macc >= rv); macc = macc - rv; zn = 1; end
        3: begin macc = ~(macc | rv); mc = 0; zn = 1; end
        4: begin mc = macc[7]; macc = macc << 1; zn = 1; end
        5: begin mc = macc[0]; macc = macc >> 1; zn = 1; end
        6: begin macc = 8'(imm); zn = 1; end
        7: begin macc = rv; zn = 1; end
        8: mr[imm] = macc;
        9: mpc = 4'(imm);
        10: mpc = rv[3:0];
        11: if (mz) mpc = 4'(imm);
        12: if (mn) mpc = 4'(imm);
`ifdef ACC_CORE_BRC_EN
        13: if (mc) mpc = 4'(imm);
`endif
        15: begin
          rr.is_halt = 1; rr.pc = mpc; rr.acc = macc; rr.z = mz; rr.n = mn; rr.c = mc;
          exp_q.push_back(rr);
          return;
        end
        default: ;
      endcase
      if (zn) begin
        mz = (macc == 0);
        mn = macc[7];
      end
    end
  endtask

  // instruction memory with programmable wait states
  initial begin
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (force_ack) begin
        imem_ack  = 1'b1;
        imem_data = force_data;
      end else if (imem_req) begin
        if (hold_ack) begin
          imem_ack = 1'b0;
        end else if (wait_cnt >= cur_wait) begin
          imem_ack  = 1'b1;
          imem_data = prog[imem_addr];
          wait_cnt  = 0;
          cur_wait  = rand_wait ? int'($urandom_range(0, 2)) : fix_wait;
        end else begin
          imem_ack  = 1'b0;
          imem_data = 8'($urandom);
          wait_cnt++;
        end
      end else begin
        wait_cnt  = 0;
        imem_ack  = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_data = 8'($urandom);
      end
    end
  end

  // monitor: pops expected state on each fetch handshake and on halt entry
  initial begin
    rec_t r;
    bit   halt_prev;
    halt_prev = 0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (imem_req && imem_ack) begin
          if (exp_q.size() == 0 || exp_q[0].is_halt) begin
            checks++; errors++;
            $display("FAIL unexpected_fetch actual_addr=%0d expected=no fetch", imem_addr);
          end else begin
            r = exp_q.pop_front();
            check("fetch_state", {imem_addr, acc, flag_z, flag_n, flag_c},
                  {r.pc, r.acc, r.z, r.n, r.c});
          end
        end else if (imem_req && exp_q.size() > 0 && !exp_q[0].is_halt) begin
          check("wait_addr", imem_addr, exp_q[0].pc);
        end
        if (halt && !halt_prev) begin
          if (exp_q.size() == 0 || !exp_q[0].is_halt) begin
            checks++; errors++;
            $display("FAIL unexpected_halt actual_pc=%0d expected=no halt", pc);
          end else begin
            r = exp_q.pop_front();
            check("halt_state", {pc, acc, flag_z, flag_n, flag_c},
                  {r.pc, r.acc, r.z, r.n, r.c});
          end
        end
      end
      halt_prev = halt;
    end
  end

  task automatic load(input logic [7:0] words [$]);
    for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
    for (int i = 0; i < words.size(); i++) prog[i] = words[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_prog(input string name, input int max_steps, input int exp_cyc);
    int cyc;
    model_run(max_steps);
    mon_en = 1;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      #3;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d pending expected=0 pending", name, exp_q.size());
      exp_q.delete();
    end else if (exp_cyc >= 0) begin
      check({name, "_cycles"}, cyc, exp_cyc);
    end
    mon_en = 0;
  endtask

  initial begin
    int         brc_pc;
    bit         found;
    logic [7:0] basic [$];
    basic = '{8'h65, 8'h81, 8'h63, 8'h11, 8'hF0};
    reset = 1'b1;
    for (int i = 0; i < 16; i++) prog[i] = 8'hF0;
    repeat (3) @(negedge clk);
    #3;
    check("reset_outputs", {imem_req, halt, pc, acc, flag_z, flag_n, flag_c}, 17'h0);

    load(basic);
    run_prog("basic", 100, 10);
    check("basic_final", {acc, flag_z, flag_n, flag_c, halt, pc}, {8'd8, 3'b000, 1'b1, 4'd5});
    do_reset();

    fix_wait = 3; cur_wait = 3;
    run_prog("waits", 100, 25);
    check("waits_final", {acc, flag_z, flag_n, flag_c, halt}, {8'd8, 3'b000, 1'b1});
    fix_wait = 0; cur_wait = 0;
    do_reset();

    load('{8'h64, 8'h82, 8'h22, 8'hB9});
    prog[9] = 8'hC3; prog[10] = 8'hF0;
    run_prog("branch", 100, -1);
    check("branch_final", {acc, flag_z, flag_n, flag_c, pc}, {8'd0, 3'b101, 4'd11});
    do_reset();

    load('{8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h83, 8'h13, 8'hDC, 8'hF0});
    prog[12] = 8'hF0;
`ifdef ACC_CORE_BRC_EN
    brc_pc = 13;
`else
    brc_pc = 9;
`endif
    run_prog("carry", 100, -1);
    check("carry_final", {acc, flag_z, flag_n, flag_c, pc}, {8'hE0, 3'b011, 4'(brc_pc)});
    do_reset();

    load('{8'h9F});
    prog[15] = 8'h00;
    run_prog("wrap", 3, -1);
    do_reset();

    // reset during a fetch wait, with a late ack arriving under reset
    load('{8'h69, 8'h00});
    @(negedge clk);
    reset = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      #3;
      if (pc == 4'd1 && !imem_req) begin
        found = 1;
        hold_ack = 1;
      end
    end
    check("midfetch_reach_exec", found, 1'b1);
    repeat (3) @(negedge clk);
    #3;
    check("midfetch_waiting", {imem_req, imem_ack, imem_addr, acc}, {1'b1, 1'b0, 4'd1, 8'd9});
    @(negedge clk);
    reset = 1'b1;
    force_ack = 1; force_data = 8'h65;
    #3;
    check("midfetch_req_drop", {imem_req, halt}, 2'b00);
    repeat (2) @(negedge clk);
    #3;
    check("midfetch_cleared", {imem_req, pc, acc, flag_z, flag_n, flag_c}, 16'h0);
    @(negedge clk);
    force_ack = 0; hold_ack = 0;
    load(basic);
    run_prog("after_reset", 100, 10);
    do_reset();

    rand_wait = 1; spur_en = 1;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      run_prog("random", 40, -1);
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acc_core.md
# acc_core

Parametrised accumulator-machine core for the CSE 664 microprocessor family. It merges the controller FSM, program counter, instruction register, accumulator, ALU, register file and operand muxes into one block. Width, register count and PC depth are generic. Instruction fetch goes through a req/ack handshake to an external instruction memory, so wait-state memories are supported. Registered flags feed conditional branches.

## Interface
- `DATA_W`, 8: accumulator, ALU and register width.
- `IMM_W`, 4: immediate / register-address width. The register file has 2^IMM_W entries.
- `PC_W`, 4: program counter width. Instruction memory depth is 2^PC_W.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_req` output 1: fetch request.
- `imem_addr` output PC_W: fetch address, equal to the PC.
- `imem_ack` input 1: fetch data valid this cycle.
- `imem_data` input 4+IMM_W: instruction; opcode in the upper 4 bits, immediate in the lower IMM_W bits.
- `pc` output PC_W: current PC.
- `acc` output DATA_W: accumulator.
- `flag_z`, `flag_n`, `flag_c` outputs 1 each: registered flags.
- `halt` output 1: core is halted.

## Operation
- Opcodes. Immediate zero-extended is written imm; register file entry r is R[r].
  - 0 NOP.
  - 1 ADD: ACC += R[imm].
  - 2 SUB: ACC -= R[imm].
  - 3 NOR: ACC = ~(ACC | R[imm]).
  - 4 SHL: ACC <<= 1.
  - 5 SHR: ACC >>= 1 (logical).
  - 6 LDI: ACC = imm.
  - 7 LDR: ACC = R[imm].
  - 8 STR: R[imm] = ACC.
  - 9 JMP: PC = imm.
  - A JMPR: PC = R[imm][PC_W-1:0].
  - B BRZ: PC = imm if Z.
  - C BRN: PC = imm if N.
  - D BRC: see Configuration.
  - E: reserved, executes as NOP.
  - F HLT.
- Branch immediates are zero-extended or truncated to PC_W.
- Arithmetic is modulo 2^DATA_W. SUB is computed as ACC + ~R + 1.
- Flag updates:
  - ALU ops (1–5) update Z, N and C.
  - LDI and LDR update Z and N; C is held.
  - All other opcodes hold every flag.
- C meaning per op:
  - ADD: carry out.
  - SUB: carry out, so 1 means no borrow.
  - SHL: bit shifted out of the MSB.
  - SHR: bit shifted out of the LSB.
  - NOR: 0.
- N is ACC[DATA_W-1]. Z is set when ACC == 0.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: `imem_req`=1 and `imem_addr`=PC. On `imem_ack`, IR <= `imem_data`, PC <= PC+1 (wraps 2^PC_W-1 to 0), next state EXEC. Without ack, stay in FETCH with the address held.
  - EXEC: one cycle; perform the op. Next state is HALT for HLT, otherwise FETCH.
  - HALT: `halt`=1 and `imem_req`=0. The core stays here until `reset`.
- A taken jump or branch overrides the increment already applied in FETCH. A not-taken branch leaves PC at PC+1.
- `imem_ack` is ignored when `imem_req`=0.

## Timing
- Reset values: PC=0, ACC=0, all flags 0, all registers 0, IR=0, state FETCH.
- Outputs while `reset` is high: `halt`=0 and `imem_req`=0.
- `imem_req` rises in the first cycle after `reset` deasserts. It is combinational from state.
- Ack may arrive in the same cycle the request is raised, which suits zero-wait memory with ack tied high. With zero wait states, each instruction takes 2 cycles; each wait cycle adds 1.
- A STR write is visible to a LDR or ALU read in the next EXEC.
- Updates in EXEC to ACC, the register file and the flags are visible at the next rising edge.
- Reset mid-operation:
  - During a FETCH wait, the request drops that cycle and a late ack is ignored.
  - During EXEC, the write is suppressed.
  - During HALT, the core restarts at PC 0.

## Configuration
- `ACC_CORE_BRC_EN` defined: opcode D is BRC, which branches to imm when C=1.
- `ACC_CORE_BRC_EN` undefined: opcode D executes as NOP. The C flag is still computed and output.

## Structure
- Package `acc_core_pkg` holds:
  - the opcode enum (4-bit);
  - the FSM state enum;
  - default width constants.
- The natural sub-module is `acc_regfile`:
  - 2^IMM_W × DATA_W;
  - one combinational read port;
  - one synchronous write port;
  - synchronous reset clear.
- The ALU and FSM stay inline.

## Test plan
- Basic program, zero wait. Program: LDI 5, STR r1, LDI 3, ADD r1, HLT. Required: acc=8, R1=5, Z=0, N=0, C=0, `halt`=1 at cycle 10 after reset release.
- Wait states. Ack delayed 3 cycles on every fetch. Required: `imem_addr` and `imem_req` stable while waiting, 5 cycles per instruction, same final state as the basic program.
- Branches on Z and N. Program: LDI 4, STR r2, SUB r2, BRZ 9. Required: Z=1, C=1, next `imem_addr`=9. Then BRN 3 with N=0: not taken, PC increments.
- Carry path. Program: LDI 15, SHL ×4 (acc=0xF0), STR r3, ADD r3. Required: acc=0xE0, C=1, N=1. Then BRC 12:
  - with `ACC_CORE_BRC_EN`, next fetch address is 12;
  - without it, the branch is not taken.
- PC wrap. Program: JMP 15, then NOP at address 15. Required: the fetch after the NOP uses `imem_addr`=0.
- Reset mid-fetch. Assert `reset` while `imem_req`=1 and ack is withheld, then give a late ack. Required: `imem_req`=0 during reset, PC=0, ACC=0, the ack has no effect, and fetch restarts at address 0.
